// File: rtl/fp4_dot_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fp4_dot_accum                                                   |
// | Purpose  : Multi-lane FP4 (E2M1) dot-product accumulator. Each accepted    |
// |            beat multiplies LANES operand pairs exactly, sums them and adds |
// |            the sum into a saturating signed fixed-point accumulator (LSB = |
// |            0.25). A block closes on i_last or after MAX_BEATS beats; its   |
// |            result leaves over a valid/ready handshake.                     |
// | Ports    : i_clk, i_rst_n (async, active-low)                              |
// |            i_valid/o_ready, i_a, i_b, i_last : input beat stream           |
// |            o_valid/i_ready, o_acc, o_sat, o_beats : block result           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fp4_dot_accum #(
   parameter int LANES     = 4,   // power of two, 1..16
   parameter int ACC_W     = 16,  // must be >= 9 + log2(LANES)
   parameter int MAX_BEATS = 256  // >= 1
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_valid,
   output logic                           o_ready,
   input  logic [4*LANES-1:0]             i_a,
   input  logic [4*LANES-1:0]             i_b,
   input  logic                           i_last,
   output logic                           o_valid,
   input  logic                           i_ready,
   output logic [ACC_W-1:0]               o_acc,
   output logic                           o_sat,
   output logic [$clog2(MAX_BEATS+1)-1:0] o_beats
);

   localparam int PROD_W = 9;
   localparam int SUM_W  = PROD_W + $clog2(LANES);
   localparam int BEAT_W = $clog2(MAX_BEATS + 1);

   localparam logic [BEAT_W-1:0]       C_BEAT_ONE  = BEAT_W'(1);
   localparam logic [BEAT_W-1:0]       C_BEAT_LAST = BEAT_W'(MAX_BEATS - 1);
   localparam logic signed [ACC_W-1:0] C_ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] C_ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

   // Magnitude of an FP4 code (sign stripped) expressed in halves.
   function automatic logic [3:0] fp4_mag(input logic [2:0] code);
      case (code[2:1])
         2'd0:    fp4_mag = {3'b000, code[0]};               // 0, 1
         2'd1:    fp4_mag = {2'b00, 1'b1, code[0]};          // 2, 3
         2'd2:    fp4_mag = {1'b0, 1'b1, code[0], 1'b0};     // 4, 6
         default: fp4_mag = {1'b1, code[0], 2'b00};          // 8, 12
      endcase
   endfunction

   // ---------------------------------------------------------------------
   // Input handshake and block framing
   // ---------------------------------------------------------------------
   logic              r_alive;   // low in reset, high from the first edge after
   logic              r_busy;    // a closed block is in flight
   logic [BEAT_W-1:0] r_in_cnt;  // beats accepted so far in the open block
   logic              w_accept;
   logic              w_close;
   logic              w_out_hs;

   assign o_ready  = r_alive & ~r_busy;
   assign w_accept = i_valid & o_ready;
   // Hitting the beat limit closes the block regardless of i_last.
   assign w_close  = i_last | (r_in_cnt == C_BEAT_LAST);
   assign w_out_hs = o_valid & i_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_alive  <= 1'b0;
         r_busy   <= 1'b0;
         r_in_cnt <= '0;
      end else begin
         r_alive <= 1'b1;
         if (w_accept && w_close) begin
            r_busy <= 1'b1;
         end else if (w_out_hs) begin
            r_busy <= 1'b0;
         end
         if (w_accept) begin
            r_in_cnt <= w_close ? '0 : r_in_cnt + C_BEAT_ONE;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Lane multipliers: exact signed products in quarters (|p| <= 144)
   // ---------------------------------------------------------------------
   logic [PROD_W*LANES-1:0] w_prod;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [3:0] w_mag_a;
      logic [3:0] w_mag_b;
      logic [7:0] w_mag_p;
      logic       w_neg;

      assign w_mag_a = fp4_mag(i_a[4*k +: 3]);
      assign w_mag_b = fp4_mag(i_b[4*k +: 3]);
      assign w_mag_p = {4'b0000, w_mag_a} * {4'b0000, w_mag_b};
      assign w_neg   = i_a[4*k+3] ^ i_b[4*k+3];
      // A negative zero magnitude negates to zero, so -0 needs no special case.
      assign w_prod[PROD_W*k +: PROD_W] = w_neg ? -{1'b0, w_mag_p} : {1'b0, w_mag_p};
   end

   // S1: lane products
   logic                    r_s1_valid;
   logic                    r_s1_close;
   logic [PROD_W*LANES-1:0] r_s1_prod;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_close <= 1'b0;
         r_s1_prod  <= '0;
      end else begin
         r_s1_valid <= w_accept;
         r_s1_close <= w_accept & w_close;
         r_s1_prod  <= w_prod;
      end
   end

   // ---------------------------------------------------------------------
   // Beat sum: the reduction is wide enough that it can never overflow
   // ---------------------------------------------------------------------
   logic signed [SUM_W-1:0] w_sum;

   always_comb begin
      w_sum = '0;
      for (int k = 0; k < LANES; k++) begin
         w_sum = w_sum + SUM_W'($signed(r_s1_prod[PROD_W*k +: PROD_W]));
      end
   end

   // S2: beat sum
   logic                    r_s2_valid;
   logic                    r_s2_close;
   logic signed [SUM_W-1:0] r_s2_sum;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_close <= 1'b0;
         r_s2_sum   <= '0;
      end else begin
         r_s2_valid <= r_s1_valid;
         r_s2_close <= r_s1_close;
         r_s2_sum   <= w_sum;
      end
   end

   // ---------------------------------------------------------------------
   // Saturating accumulate. One guard bit suffices because the beat sum is
   // never wider than the accumulator; overflow shows as the top two bits
   // of the widened sum disagreeing.
   // ---------------------------------------------------------------------
   logic signed [ACC_W-1:0] r_acc;
   logic                    r_sat;
   logic [BEAT_W-1:0]       r_beats;
   logic signed [ACC_W:0]   w_acc_wide;
   logic                    w_ovf;
   logic signed [ACC_W-1:0] w_acc_next;

   assign w_acc_wide = (ACC_W+1)'(r_acc) + (ACC_W+1)'(r_s2_sum);
   assign w_ovf      = w_acc_wide[ACC_W] ^ w_acc_wide[ACC_W-1];
   assign w_acc_next = w_ovf ? (w_acc_wide[ACC_W] ? C_ACC_MIN : C_ACC_MAX)
                             : w_acc_wide[ACC_W-1:0];

   // S3: accumulator and output register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc   <= '0;
         r_sat   <= 1'b0;
         r_beats <= '0;
         o_valid <= 1'b0;
         o_acc   <= '0;
         o_sat   <= 1'b0;
         o_beats <= '0;
      end else begin
         if (w_out_hs) begin
            o_valid <= 1'b0;
         end
         if (r_s2_valid) begin
            if (r_s2_close) begin
               // Input is stalled until the handshake, so o_valid is free here.
               o_valid <= 1'b1;
               o_acc   <= w_acc_next;
               o_sat   <= r_sat | w_ovf;
               o_beats <= r_beats + C_BEAT_ONE;
               r_acc   <= '0;
               r_sat   <= 1'b0;
               r_beats <= '0;
            end else begin
               r_acc   <= w_acc_next;
               r_sat   <= r_sat | w_ovf;
               r_beats <= r_beats + C_BEAT_ONE;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fp4_dot_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fp4_dot_accum                                                |
// | Purpose  : Self-checking bench for fp4_dot_accum (LANES=4, ACC_W=12,       |
// |            MAX_BEATS=8). Directed cases then random blocks, all compared   |
// |            against an arithmetic reference model of the block results.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_fp4_dot_accum;

   localparam int LANES     = 4;
   localparam int ACC_W     = 12;
   localparam int MAX_BEATS = 8;
   localparam int W         = 4 * LANES;
   localparam int ACC_MAXV  = (1 << (ACC_W - 1)) - 1;
   localparam int ACC_MINV  = -(1 << (ACC_W - 1));

   logic                           clk = 1'b0;
   logic                           rst_n = 1'b0;
   logic                           i_valid = 1'b0;
   logic                           o_ready;
   logic [W-1:0]                   i_a = '0;
   logic [W-1:0]                   i_b = '0;
   logic                           i_last = 1'b0;
   logic                           o_valid;
   logic                           i_ready = 1'b0;
   logic [ACC_W-1:0]               o_acc;
   logic                           o_sat;
   logic [$clog2(MAX_BEATS+1)-1:0] o_beats;

   always #5 clk = ~clk;

   fp4_dot_accum #(.LANES(LANES), .ACC_W(ACC_W), .MAX_BEATS(MAX_BEATS)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_a     (i_a),
      .i_b     (i_b),
      .i_last  (i_last),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_acc   (o_acc),
      .o_sat   (o_sat),
      .o_beats (o_beats)
   );

   typedef struct {
      int acc;
      bit sat;
      int beats;
   } res_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   m_acc    = 0;
   bit   m_sat    = 1'b0;
   int   m_beats  = 0;
   bit   blk_closed = 1'b0;
   res_t exp_q[$];

   // Real value of an FP4 code, in halves.
   function automatic int fp4_val(input logic [3:0] c);
      int tab[8] = '{0, 1, 2, 3, 4, 6, 8, 12};
      return c[3] ? -tab[c[2:0]] : tab[c[2:0]];
   endfunction

   function automatic logic [W-1:0] rand_word();
      return W'($urandom);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Presents one beat, waits for acceptance, and updates the reference model.
   task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
      int guard = 0;
      int sum   = 0;
      i_valid = 1'b1;
      i_a     = a;
      i_b     = b;
      i_last  = last;
      while (!o_ready && guard < 50) begin
         tick();
         guard++;
      end
      check("accept_wait", o_ready, 1);
      tick();
      for (int k = 0; k < LANES; k++) begin
         sum += fp4_val(a[4*k +: 4]) * fp4_val(b[4*k +: 4]);
      end
      m_acc += sum;
      if (m_acc > ACC_MAXV) begin m_acc = ACC_MAXV; m_sat = 1'b1; end
      if (m_acc < ACC_MINV) begin m_acc = ACC_MINV; m_sat = 1'b1; end
      m_beats++;
      blk_closed = last || (m_beats == MAX_BEATS);
      if (blk_closed) begin
         exp_q.push_back('{acc: m_acc, sat: m_sat, beats: m_beats});
         m_acc   = 0;
         m_sat   = 1'b0;
         m_beats = 0;
      end
   endtask

   // Waits for the pending result, holds i_ready low for 'hold' cycles while
   // offering junk beats that must be ignored, then completes the handshake.
   task automatic get_result(input string tag, input int hold);
      int   guard = 0;
      res_t e;
      i_ready = 1'b0;
      i_valid = 1'b1;
      i_a     = rand_word();
      i_b     = rand_word();
      i_last  = 1'($urandom);
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL %s_queue: observed empty expected one result", tag);
         return;
      end
      e = exp_q.pop_front();
      while (!o_valid && guard < 50) begin
         check({tag, "_ready_busy"}, o_ready, 0);
         tick();
         guard++;
      end
      check({tag, "_valid"}, o_valid, 1);
      for (int h = 0; h <= hold; h++) begin
         check({tag, "_acc"},   $signed(o_acc), e.acc);
         check({tag, "_sat"},   o_sat,          32'(e.sat));
         check({tag, "_beats"}, o_beats,        e.beats);
         check({tag, "_ready_hold"}, o_ready,   0);
         if (h < hold) tick();
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      check({tag, "_ready_after"}, o_ready, 1);
      check({tag, "_valid_after"}, o_valid, 0);
   endtask

   // Asynchronous reset asserted between clock edges, released after two edges.
   task automatic do_reset();
      i_valid = 1'b0;
      i_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_valid", o_valid, 0);
      check("rst_ready", o_ready, 0);
      m_acc   = 0;
      m_sat   = 1'b0;
      m_beats = 0;
      exp_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_ready_release", o_ready, 0);
      tick();
      check("rst_ready_first", o_ready, 1);
   endtask

   initial begin
      // Power-on reset
      #3;
      check("por_valid", o_valid, 0);
      check("por_ready", o_ready, 0);
      check("por_acc",   $signed(o_acc), 0);
      check("por_sat",   o_sat, 0);
      check("por_beats", o_beats, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("por_ready_first", o_ready, 1);

      // 1.0 x 1.0 on every lane, with exact latency check
      send_beat(16'h2222, 16'h2222, 1'b1);
      check("lat_n1", o_valid, 0);
      tick();
      check("lat_n2", o_valid, 0);
      tick();
      check("lat_n3", o_valid, 1);
      get_result("one", 0);

      // Mixed signs including -0: -36 + 0.25 + 3 + 0 = -32.75
      send_beat(16'h8317, 16'h541F, 1'b1);
      get_result("mixed", 0);

      // Positive saturation over 5 beats, then a clean block
      for (int i = 1; i <= 5; i++) send_beat(16'h7777, 16'h7777, i == 5);
      get_result("sat_pos", 0);
      send_beat(16'h2222, 16'h2222, 1'b1);
      get_result("after_sat", 0);

      // Negative saturation
      for (int i = 1; i <= 4; i++) send_beat(16'h7777, 16'hFFFF, i == 4);
      get_result("sat_neg", 0);

      // Auto-close at MAX_BEATS, remainder closed by i_last
      for (int i = 1; i <= MAX_BEATS + 2; i++) begin
         send_beat(16'h2222, 16'h2222, i == MAX_BEATS + 2);
         if (blk_closed) get_result("maxbeats", 0);
      end

      // Backpressure hold for 10 cycles, all-zero products still count
      send_beat(16'h0000, 16'h7777, 1'b0);
      send_beat(16'h1111, 16'h1111, 1'b1);
      get_result("hold", 10);

      // Reset while a result is waiting: no result survives
      send_beat(16'h2222, 16'h2222, 1'b1);
      tick();
      tick();
      check("midout_valid", o_valid, 1);
      do_reset();

      // Reset mid-block, then a fresh single-beat block
      for (int i = 0; i < 3; i++) send_beat(16'h7777, 16'h7777, 1'b0);
      do_reset();
      send_beat(16'h2222, 16'h2222, 1'b1);
      get_result("post_reset", 0);

      // Random blocks with bubbles and random backpressure
      for (int blk = 0; blk < 14; blk++) begin
         int len;
         len = $urandom_range(1, MAX_BEATS + 3);
         for (int j = 1; j <= len; j++) begin
            if ($urandom_range(0, 3) == 0) begin
               i_valid = 1'b0;
               i_a     = rand_word();
               tick();
            end
            send_beat(rand_word(), rand_word(), j == len);
            if (blk_closed) get_result("rand", $urandom_range(0, 3));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/fp4_dot_accum.md
# fp4_dot_accum

Parametrised FP4 (E2M1) dot-product accumulator. Each accepted beat multiplies LANES pairs of FP4 operands exactly, sums the products in an adder tree and adds the sum into a wide signed fixed-point accumulator. A block closes on `i_last` or after MAX_BEATS beats, and its result goes out over a valid/ready handshake. This is the successor to the single-lane FP4 MAC top: it adds lanes, exact wide accumulation, block framing, saturation reporting and backpressure.

## Interface
- LANES, default 4: operand pairs per beat (power of two, 1..16).
- ACC_W, default 16: accumulator width, signed, 2 fractional bits (LSB = 0.25).
- MAX_BEATS, default 256: the block auto-closes at this beat count (≥1).
- i_clk  in  1: clock; all logic on the rising edge.
- i_rst_n  in  1: reset, asynchronous, active-low.
- i_valid  in  1: input beat valid.
- o_ready  out  1: input beat accepted when i_valid && o_ready.
- i_a  in  4*LANES: lane k operand A is bits [4k+3:4k].
- i_b  in  4*LANES: lane k operand B, same packing as i_a.
- i_last  in  1: the beat closes the current block.
- o_valid  out  1: result valid.
- i_ready  in  1: downstream accepts the result when o_valid && i_ready.
- o_acc  out  ACC_W: block result, signed, LSB = 0.25.
- o_sat  out  1: the accumulator saturated at least once in this block.
- o_beats  out  $clog2(MAX_BEATS+1): number of beats in this block.

## Operation
- FP4 decode: bit3 is the sign, bits[2:1] are the exponent e, bit0 is the mantissa m. Magnitude in halves is m when e=0, otherwise (2+m)<<(e-1). The eight codes give 0,1,2,3,4,6,8,12, i.e. 0,0.5,1,1.5,2,3,4,6. −0 equals 0.
- Lane product = signed product of the halves values, in quarters. The range is ±144 (9-bit signed) and the product is exact.
- Beat sum = sum of the LANES products, width 9+log2(LANES). It is exact and sign-extended to ACC_W.
- Accumulate: acc_next = acc + beat_sum, clamped to [−2^(ACC_W−1), 2^(ACC_W−1)−1]. Any clamp sets sticky sat for the block.
- Block close happens on an accepted beat with i_last=1, or on the accepted beat that takes the count to MAX_BEATS; i_last is then ignored.
- The closing beat's accumulated value, sat and count load into the output register. The accumulator, sat and count then clear for the next block.
- Only one closed block is allowed in flight. o_ready drops in the cycle after a closing beat is accepted. It returns in the cycle after the output handshake completes.
- o_acc, o_sat and o_beats hold stable while o_valid=1 and i_ready=0.
- No beat is accepted while o_ready=0. Inputs in that state are ignored.

## Timing
- Reset (async assert, sync deassert on i_clk) sets:
  - o_valid=0, o_acc=0, o_sat=0, o_beats=0.
  - o_ready=0 during reset, 1 on the first cycle after reset.
  - pipeline valids, accumulator and counters to 0.
- Pipeline stages:
  - S1 registers the lane products.
  - S2 registers the beat sum.
  - S3 registers the accumulator and output.
- Latency: closing beat accepted at cycle N gives o_valid=1 at cycle N+3.
- Throughput: 1 beat/cycle within a block. The minimum block-to-block gap is 3 cycles plus the cycles o_valid waits for i_ready.
- If i_ready=1 at cycle N+3, o_ready=1 at N+4 and a new beat can be accepted at N+4.
- Reset mid-block or mid-output drops all state. No result is emitted for that block.
- A beat with all-zero products still counts toward o_beats and MAX_BEATS.

## Test plan
- LANES=4: one beat with all lanes a=0x2, b=0x2 (1.0×1.0), i_last=1 -> 3 cycles later o_acc=16 (4.0), o_sat=0, o_beats=1.
- Mixed signs, one beat, lanes (0x7,0xF),(0x1,0x1),(0x3,0x4),(0x8,0x5) -> products −36, 0.25, 3, 0 -> o_acc=−131 (−32.75).
- ACC_W=12: 5 beats of all lanes 0x7×0x7 (+576/beat), last on beat 5 -> o_acc=2047, o_sat=1, o_beats=5. The next block of one beat of 0x2×0x2 -> o_acc=16, o_sat=0.
- MAX_BEATS=4: 6 beats of 0x2×0x2 with i_last never set -> first result after beat 4 with o_acc=64, o_beats=4. o_ready=0 until handshake. After i_last on beat 6 -> o_acc=32, o_beats=2.
- Hold i_ready=0 for 10 cycles after o_valid -> outputs stable and o_ready=0 throughout. Release -> o_ready=1 the next cycle.
- Assert i_rst_n=0 asynchronously mid-block with no clock edge -> o_valid=0 and o_ready=0 immediately. After release, a single 0x2×0x2 last beat -> o_acc=16, o_beats=1.
